// File: rtl/fcmp_pipe.sv
// Two-stage handshaked floating-point compare/select (FEQ/FLT/FLE/FMIN/FMAX).
// Operands are mapped to unsigned order keys so one unsigned compare orders all values.
module fcmp_pipe #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  typedef enum logic [2:0] {
    OP_FEQ  = 3'b000,
    OP_FLT  = 3'b001,
    OP_FLE  = 3'b010,
    OP_FMIN = 3'b011,
    OP_FMAX = 3'b100
  } op_e;

  logic             v1;
  logic [31:0]      s1_k1, s1_k2, s1_x1, s1_x2;
  op_e              s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic             advance1, advance2;
  logic             lt, eq;
  logic [31:0]      y_next;
  logic             ill_next;

  // +0 and -0 share one key; negatives order by inverted magnitude below all positives.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[30:0] == 31'd0)
      return 32'h8000_0000;
    else if (x[31])
      return {1'b0, ~x[30:0]};
    else
      return {1'b1, x[30:0]};
  endfunction

  assign advance2 = !out_valid || out_ready;
  assign advance1 = !v1 || advance2;
  assign in_ready = advance1;
  assign busy     = v1 || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      s1_k1  <= '0;
      s1_k2  <= '0;
      s1_x1  <= '0;
      s1_x2  <= '0;
      s1_op  <= OP_FEQ;
      s1_tag <= '0;
    end else if (advance1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_k1  <= order_key(in_x1);
        s1_k2  <= order_key(in_x2);
        s1_x1  <= in_x1;
        s1_x2  <= in_x2;
        s1_op  <= op_e'(in_op);
        s1_tag <= in_tag;
      end
    end
  end

  always_comb begin
    lt       = s1_k1 < s1_k2;
    eq       = s1_k1 == s1_k2;
    y_next   = '0;
    ill_next = 1'b0;
    case (s1_op)
      OP_FEQ:  y_next = {31'd0, eq};
      OP_FLT:  y_next = {31'd0, lt};
      OP_FLE:  y_next = {31'd0, lt | eq};
      OP_FMIN: y_next = lt ? s1_x1 : s1_x2;
      OP_FMAX: y_next = lt ? s1_x2 : s1_x1;
      default: ill_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (advance2) begin
      out_valid <= v1;
      if (v1) begin
        out_y       <= y_next;
        out_tag     <= s1_tag;
        out_illegal <= ill_next;
      end
    end
  end

endmodule
